// File: rtl/gray_sync_decoder_if.sv
// Bundles the Gray-count input, control strobes and decoded status of gray_sync_decoder.
// master drives count/controls and observes status; slave is the decoder itself.
interface gray_sync_decoder_if #(
    parameter int W         = 4,
    parameter int ERR_CNT_W = 8
);
    logic                 en;
    logic [W-1:0]         g_in;
    logic                 err_clr;
    logic [W-1:0]         g_sync;
    logic [W-1:0]         b_out;
    logic                 chg;
    logic                 dir;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output en, g_in, err_clr,
        input  g_sync, b_out, chg, dir, err, err_cnt
    );

    modport slave (
        input  en, g_in, err_clr,
        output g_sync, b_out, chg, dir, err, err_cnt
    );
endinterface

// File: rtl/gray_sync_decoder.sv
// Synchronises a foreign-domain Gray count, decodes it to binary and classifies each change.
// Latency: g_in stable before edge k shows on b_out/chg/err/dir after edge k+SYNC_STAGES.
// No backpressure: samples every cycle; en only gates tracking, never the synchroniser.
module gray_sync_decoder #(
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    gray_sync_decoder_if.slave bus
);
    localparam logic [0:0]           PRIME   = 1'b0;
    localparam logic [0:0]           TRACK   = 1'b1;
    localparam logic [W-1:0]         ONE_W   = W'(1);
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    logic [W-1:0]         sync_q [SYNC_STAGES];
    logic [W-1:0]         g_sync;
    logic [W-1:0]         b_dec;
    logic [W-1:0]         g_prev;
    logic [W-1:0]         diff;
    logic                 single_step;
    logic                 multi_step;
    logic                 step_up;
    logic                 err_evt;
    logic [0:0]           state;
    logic [W-1:0]         b_out_q;
    logic                 chg_q;
    logic                 dir_q;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= bus.g_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign g_sync = sync_q[SYNC_STAGES-1];

    // Binary bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        b_dec = '0;
        for (int i = 0; i < W; i++) b_dec[i] = ^(g_sync >> i);
    end

    // Clearing the lowest set bit leaves something only if two or more bits flipped.
    assign diff        = g_sync ^ g_prev;
    assign multi_step  = |(diff & (diff - ONE_W));
    assign single_step = (diff != '0) && !multi_step;
    assign step_up     = (b_dec == (b_out_q + ONE_W));
    assign err_evt     = (state == TRACK) && bus.en && multi_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PRIME;
            g_prev  <= '0;
            b_out_q <= '0;
            dir_q   <= 1'b0;
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            chg_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                PRIME: begin
                    if (bus.en) begin
                        b_out_q <= b_dec;
                        g_prev  <= g_sync;
                        state   <= TRACK;
                    end
                end
                TRACK: begin
                    if (!bus.en) begin
                        state <= PRIME;
                    end else if (single_step) begin
                        chg_q   <= 1'b1;
                        dir_q   <= step_up;
                        b_out_q <= b_dec;
                        g_prev  <= g_sync;
                    end else if (multi_step) begin
                        // Illegal jump: flag it but resynchronise to the new value.
                        err_q   <= 1'b1;
                        b_out_q <= b_dec;
                        g_prev  <= g_sync;
                    end
                end
                default: state <= PRIME;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (bus.err_clr) begin
            err_cnt_q <= err_evt ? CNT_ONE : '0;
        end else if (err_evt && (err_cnt_q != CNT_MAX)) begin
            err_cnt_q <= err_cnt_q + CNT_ONE;
        end
    end

    assign bus.g_sync  = g_sync;
    assign bus.b_out   = b_out_q;
    assign bus.chg     = chg_q;
    assign bus.dir     = dir_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_gray_sync_decoder.sv
// Drives two decoders (8-bit and 2-bit error counters) with directed and random Gray
// sequences and checks them every cycle against a behavioural model.
module tb_gray_sync_decoder;
    localparam int W  = 4;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       err_clr;
    logic [3:0] g_in;

    int n_vec = 0;
    int n_err = 0;

    gray_sync_decoder_if #(.W(W), .ERR_CNT_W(8)) ifa ();
    gray_sync_decoder_if #(.W(W), .ERR_CNT_W(2)) ifb ();

    assign ifa.en = en;  assign ifa.g_in = g_in;  assign ifa.err_clr = err_clr;
    assign ifb.en = en;  assign ifb.g_in = g_in;  assign ifb.err_clr = err_clr;

    gray_sync_decoder #(.W(W), .SYNC_STAGES(SS), .ERR_CNT_W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(ifa));
    gray_sync_decoder #(.W(W), .SYNC_STAGES(SS), .ERR_CNT_W(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: search for the binary value whose Gray code matches.
    function automatic int gdec(input int g);
        for (int b = 0; b < 16; b++) if ((b ^ (b >> 1)) == g) return b;
        return -1;
    endfunction

    function automatic int genc(input int b);
        return b ^ (b >> 1);
    endfunction

    // Behavioural model
    int q[$];
    int m_gs, m_old, m_b, m_prev, m_d, m_nb;
    bit m_primed, m_dir, m_chg, m_err;
    int m_cnt8, m_cnt2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q = {};
            for (int i = 0; i < SS; i++) q.push_back(0);
            m_gs = 0; m_b = 0; m_prev = 0; m_primed = 0;
            m_dir = 0; m_chg = 0; m_err = 0; m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            m_old = q[0];
            q.push_back(int'(g_in));
            void'(q.pop_front());
            m_gs  = q[0];
            m_chg = 0;
            m_err = 0;
            if (!m_primed) begin
                if (en) begin
                    m_b = gdec(m_old); m_prev = m_old; m_primed = 1;
                end
            end else if (!en) begin
                m_primed = 0;
            end else begin
                m_d  = $countones(m_old ^ m_prev);
                m_nb = gdec(m_old);
                if (m_d == 1) begin
                    m_chg = 1;
                    m_dir = (((m_nb - m_b) & 15) == 1);
                end
                if (m_d >= 2) m_err = 1;
                if (m_d >= 1) begin
                    m_b = m_nb; m_prev = m_old;
                end
            end
            if (err_clr) begin
                m_cnt8 = m_err ? 1 : 0;
                m_cnt2 = m_err ? 1 : 0;
            end else if (m_err) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
            end
        end
    end

    always @(negedge clk) begin
        check("g_sync",   ifa.g_sync,  m_gs);
        check("b_out",    ifa.b_out,   m_b);
        check("chg",      ifa.chg,     m_chg);
        check("dir",      ifa.dir,     m_dir);
        check("err",      ifa.err,     m_err);
        check("err_cnt8", ifa.err_cnt, m_cnt8);
        check("b_out_2",  ifb.b_out,   m_b);
        check("chg_2",    ifb.chg,     m_chg);
        check("dir_2",    ifb.dir,     m_dir);
        check("err_2",    ifb.err,     m_err);
        check("err_cnt2", ifb.err_cnt, m_cnt2);
    end

    task automatic step(input logic [3:0] g);
        g_in = g;
        repeat (3) @(negedge clk);
    endtask

    int r, b;

    initial begin
        rst_n = 1'b0; en = 1'b1; err_clr = 1'b0; g_in = 4'b0000;
        repeat (2) @(negedge clk);
        check("lit_rst_b_out", ifa.b_out, 0);
        check("lit_rst_cnt",   ifa.err_cnt, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("lit_idle_b_out", ifa.b_out, 0);
        check("lit_idle_chg",   ifa.chg, 0);
        check("lit_idle_err",   ifa.err, 0);

        // Full up-count, one step per cycle, including the 15->0 wrap
        for (int i = 1; i <= 18; i++) begin
            if (i <= 16) g_in = 4'(genc(i & 15));
            @(negedge clk);
            if (i >= 3) begin
                check("lit_cnt_b_out", ifa.b_out, (i - 2) & 15);
                check("lit_cnt_chg",   ifa.chg, 1);
                check("lit_cnt_dir",   ifa.dir, 1);
            end
        end

        step(4'b1000);
        check("lit_down_wrap_b", ifa.b_out, 15);
        check("lit_down_wrap_c", ifa.chg, 1);
        check("lit_down_wrap_d", ifa.dir, 0);
        step(4'b1001);
        check("lit_down_b", ifa.b_out, 14);
        check("lit_down_d", ifa.dir, 0);
        step(4'b1000);
        step(4'b0000);
        check("lit_back0_b", ifa.b_out, 0);

        step(4'b0011);
        check("lit_jump_err", ifa.err, 1);
        check("lit_jump_chg", ifa.chg, 0);
        check("lit_jump_b",   ifa.b_out, 2);
        check("lit_jump_cnt", ifa.err_cnt, 1);
        @(negedge clk);
        check("lit_jump_pulse", ifa.err, 0);
        step(4'b0010);
        check("lit_after_c", ifa.chg, 1);
        check("lit_after_d", ifa.dir, 1);
        check("lit_after_b", ifa.b_out, 3);

        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        check("lit_clr_cnt2", ifb.err_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            step((i % 2 == 0) ? 4'b1101 : 4'b0010);
            check("lit_sat_err", ifa.err, 1);
        end
        check("lit_sat_cnt2", ifb.err_cnt, 3);
        check("lit_sat_cnt8", ifa.err_cnt, 5);
        g_in = 4'b0010;
        repeat (2) @(negedge clk);
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        check("lit_clr_err_cnt2", ifb.err_cnt, 1);
        check("lit_clr_err_cnt8", ifa.err_cnt, 1);
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        check("lit_clr_only", ifb.err_cnt, 0);

        step(4'b0011);
        step(4'b0001);
        check("lit_pre_en_b", ifa.b_out, 1);
        en = 1'b0;
        step(4'b0110);
        check("lit_dis_b",   ifa.b_out, 1);
        check("lit_dis_chg", ifa.chg, 0);
        check("lit_dis_err", ifa.err, 0);
        en = 1'b1;
        @(negedge clk);
        check("lit_prime_b",   ifa.b_out, 4);
        check("lit_prime_chg", ifa.chg, 0);
        check("lit_prime_err", ifa.err, 0);
        step(4'b0111);
        check("lit_resume_c", ifa.chg, 1);
        check("lit_resume_d", ifa.dir, 1);
        check("lit_resume_b", ifa.b_out, 5);

        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("lit_async_b",  ifa.b_out, 0);
        check("lit_async_gs", ifa.g_sync, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("lit_rel_b",   ifa.b_out, 0);
        check("lit_rel_chg", ifa.chg, 0);
        check("lit_rel_err", ifa.err, 0);

        // Randomised phase: mostly legal steps, some holds, jumps, en toggles, clears, resets
        for (int n = 0; n < 2500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                b = gdec(int'(g_in));
                b = (b + (($urandom_range(0, 1) == 1) ? 1 : 15)) & 15;
                g_in = 4'(genc(b));
            end else if (r >= 70 && r < 85) begin
                g_in = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 99) < 4) en = ~en;
            err_clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/gray_sync_decoder.md
Name: gray_sync_decoder

Overview:
Downstream consumer of the 4-bit binary-to-Gray stage. Takes a Gray-coded count that may be produced in an unrelated timing domain. Synchronises it into the local clock with a flop chain, converts Gray back to binary, and classifies each new sample as hold, up-step, down-step or illegal multi-bit jump. It reports the decoded binary count, direction strobes and a saturating error counter to downstream control logic.

Parameters:
W, 4, Gray/binary word width (>=2)
SYNC_STAGES, 2, synchroniser flop depth (>=2)
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  decode/track enable; synchroniser runs regardless
g_in  input  W  Gray-coded count, asynchronous to clk
err_clr  input  1  synchronous clear of err_cnt
g_sync  output  W  last synchroniser stage (Gray)
b_out  output  W  decoded binary count, registered
chg  output  1  one-cycle pulse: legal single-step change
dir  output  1  direction of last legal step (1=up, 0=down), held
err  output  1  one-cycle pulse: illegal multi-bit Gray change
err_cnt  output  ERR_CNT_W  saturating count of err pulses

Behaviour:
- Reset (rst_n=0, async, immediate): all sync flops, g_prev, b_out, dir, chg, err, err_cnt = 0; FSM -> PRIME.
- Synchroniser: SYNC_STAGES flops, shift every edge, no enable. g_sync = last stage.
- Gray->binary (combinational on g_sync): b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
- Latency: g_in stable before edge k -> g_sync valid after edge k+SYNC_STAGES-1 -> b_out/chg/err/dir updated at edge k+SYNC_STAGES.
- FSM, 2 states:
  - PRIME: if en=1: b_out<=decode(g_sync), g_prev<=g_sync, chg=0, err=0, -> TRACK. If en=0: hold in PRIME.
  - TRACK: if en=0: hold b_out/g_prev/dir, chg=err=0, -> PRIME. Else compute hamming distance hd = popcount(g_sync ^ g_prev):
    - hd=0: no update, chg=err=0.
    - hd=1: chg=1; dir=1 if decode(g_sync)==b_out+1 mod 2^W, else dir=0 (it is then b_out-1 mod 2^W); b_out, g_prev updated.
    - hd>=2: err=1, chg=0, dir held; b_out and g_prev still take the new value (resynchronise).
- Wrap-around: max->0 is a legal up-step; 0->max is a legal down-step.
- chg and err are mutually exclusive and never asserted in PRIME.
- err_cnt: +1 per err pulse, saturates at 2^ERR_CNT_W-1, never wraps.
- err_clr=1: err_cnt<=0. If err_clr and err coincide, err_cnt<=1.
- Reset mid-operation: outputs clear asynchronously. After release, the first enabled sample primes without flagging.

Test Plan:
- Reset, g_in=0000 held, en=1 -> b_out=0, chg=0, err=0 throughout; err_cnt=0.
- en=1, g_in steps 0000,0001,0011,0010,...,1000,0000, one per cycle -> b_out 0,1,2,3,...,15,0 lagging by SYNC_STAGES+1 edges; chg=1 each step; dir=1 including 15->0 wrap.
- From b_out=0, g_in=1000 -> b_out=15, chg=1, dir=0. Next, g_in=1001 -> b_out=14, dir=0.
- From 0000, g_in=0011 -> err=1 for one cycle, chg=0, b_out=2, err_cnt=1. Next, g_in=0010 -> chg=1, dir=1, b_out=3.
- ERR_CNT_W=2, five illegal jumps -> err_cnt=3, saturated. Then err_clr together with a sixth jump -> err_cnt=1. Then err_clr alone -> err_cnt=0.
- en=0 at b_out=1, g_in moves 0001->0110. Then en=1 -> PRIME loads b_out=4, no err/chg. Next, g_in=0111 -> chg=1, dir=1, b_out=5. Drop rst_n mid-stream -> b_out=0 immediately, without waiting for a clock edge.
